// File: rtl/arb_pkg.sv
// Shared definitions for the two-requester RAM arbiter: FSM encoding,
// requester identifiers and the legal access-length bounds.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam logic [1:0] REQ_CPU = 2'd0;
    localparam logic [1:0] REQ_LDR = 2'd1;

    localparam int ACCESS_CYCLES_MIN = 1;
    localparam int ACCESS_CYCLES_MAX = 15;
    localparam int CNT_W             = 4;

endpackage

// File: rtl/arb_select.sv
// Combinational winner selection between the CPU and the loader.
// Define ARB_ROUND_ROBIN_EN to alternate on contention; otherwise the CPU wins.
module arb_select
    import arb_pkg::*;
(
    input  logic       cpu_req,
    input  logic       ldr_req,
    input  logic [1:0] last_grant,
    output logic       any_req,
    output logic [1:0] winner
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        any_req = cpu_req | ldr_req;
        winner  = REQ_CPU;
        if (cpu_req && ldr_req) begin
            winner = (last_grant == REQ_CPU) ? REQ_LDR : REQ_CPU;
        end else if (ldr_req) begin
            winner = REQ_LDR;
        end
    end
`else
    // Fixed priority ignores the grant history; keep it visibly consumed.
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    always_comb begin
        any_req = cpu_req | ldr_req;
        winner  = REQ_CPU;
        if (!cpu_req && ldr_req) begin
            winner = REQ_LDR;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port RAM between the CPU MEM stage and a loader.
// Contention policy is selected by the ARB_ROUND_ROBIN_EN macro (see arb_select).
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int ACCESS_CYCLES = 1,
    parameter int ADDR_W        = 8
) (
    input  logic              clk,
    input  logic              R,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic              cpu_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic              ldr_req,
    input  logic              ldr_rw,
    input  logic              ldr_size,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [31:0]       ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_done,
    output logic [31:0]       ldr_rdata,
    output logic              ram_E,
    output logic              ram_RW,
    output logic              ram_Size,
    output logic [ADDR_W-1:0] ram_A,
    output logic [31:0]       ram_DI,
    input  logic [31:0]       ram_DO
);

    localparam int AC_EFF = (ACCESS_CYCLES > ACCESS_CYCLES_MAX) ? ACCESS_CYCLES_MAX :
                            (ACCESS_CYCLES < ACCESS_CYCLES_MIN) ? ACCESS_CYCLES_MIN :
                            ACCESS_CYCLES;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(AC_EFF - 1);

    arb_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        owner;
    logic              lat_rw, lat_size;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic              any_req;
    logic [1:0]        winner;
    logic              start, finish;

    arb_select u_select (
        .cpu_req    (cpu_req),
        .ldr_req    (ldr_req),
        .last_grant (owner),
        .any_req    (any_req),
        .winner     (winner)
    );

    always_ff @(posedge clk or posedge R) begin
        if (R) state <= IDLE;
        else   state <= state_nxt;
    end

    // Grants are combinational in the IDLE cycle, masked while reset is held.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        finish    = 1'b0;
        cpu_gnt   = 1'b0;
        ldr_gnt   = 1'b0;
        cpu_done  = 1'b0;
        ldr_done  = 1'b0;
        ram_E     = 1'b0;
        ram_RW    = 1'b0;
        case (state)
            IDLE: begin
                if (any_req && !R) begin
                    start     = 1'b1;
                    cpu_gnt   = (winner == REQ_CPU);
                    ldr_gnt   = (winner == REQ_LDR);
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                ram_E  = 1'b1;
                ram_RW = lat_rw;
                if (cnt == '0) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                cpu_done  = (owner == REQ_CPU);
                ldr_done  = (owner == REQ_LDR);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The winner's fields are frozen at grant so later requester changes are ignored.
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            cnt       <= '0;
            owner     <= REQ_LDR;
            lat_rw    <= 1'b0;
            lat_size  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cpu_rdata <= '0;
            ldr_rdata <= '0;
        end else begin
            if (start) begin
                cnt       <= CNT_LOAD;
                owner     <= winner;
                lat_rw    <= (winner == REQ_CPU) ? cpu_rw    : ldr_rw;
                lat_size  <= (winner == REQ_CPU) ? cpu_size  : ldr_size;
                lat_addr  <= (winner == REQ_CPU) ? cpu_addr  : ldr_addr;
                lat_wdata <= (winner == REQ_CPU) ? cpu_wdata : ldr_wdata;
            end else if (state == ACCESS && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (finish && !lat_rw) begin
                if (owner == REQ_CPU) cpu_rdata <= ram_DO;
                else                  ldr_rdata <= ram_DO;
            end
        end
    end

    assign ram_Size  = lat_size;
    assign ram_A     = lat_addr;
    assign ram_DI    = lat_wdata;
    assign cpu_stall = cpu_req & ~cpu_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 uses ACCESS_CYCLES=1, instance 1 uses 3.
// Expectations for contention follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic R;
    always #5 clk = ~clk;

    logic        cpu_req [2], cpu_rw [2], cpu_size [2];
    logic [7:0]  cpu_addr [2];
    logic [31:0] cpu_wdata [2];
    logic        cpu_gnt [2], cpu_done [2], cpu_stall [2];
    logic [31:0] cpu_rdata [2];
    logic        ldr_req [2], ldr_rw [2], ldr_size [2];
    logic [7:0]  ldr_addr [2];
    logic [31:0] ldr_wdata [2];
    logic        ldr_gnt [2], ldr_done [2];
    logic [31:0] ldr_rdata [2];
    logic        ram_E [2], ram_RW [2], ram_Size [2];
    logic [7:0]  ram_A [2];
    logic [31:0] ram_DI [2], ram_DO [2];

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.ACCESS_CYCLES(1), .ADDR_W(8)) u_dut0 (
        .clk(clk), .R(R),
        .cpu_req(cpu_req[0]), .cpu_rw(cpu_rw[0]), .cpu_size(cpu_size[0]),
        .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
        .cpu_gnt(cpu_gnt[0]), .cpu_done(cpu_done[0]), .cpu_rdata(cpu_rdata[0]),
        .cpu_stall(cpu_stall[0]),
        .ldr_req(ldr_req[0]), .ldr_rw(ldr_rw[0]), .ldr_size(ldr_size[0]),
        .ldr_addr(ldr_addr[0]), .ldr_wdata(ldr_wdata[0]),
        .ldr_gnt(ldr_gnt[0]), .ldr_done(ldr_done[0]), .ldr_rdata(ldr_rdata[0]),
        .ram_E(ram_E[0]), .ram_RW(ram_RW[0]), .ram_Size(ram_Size[0]),
        .ram_A(ram_A[0]), .ram_DI(ram_DI[0]), .ram_DO(ram_DO[0])
    );

    mem_arbiter #(.ACCESS_CYCLES(3), .ADDR_W(8)) u_dut1 (
        .clk(clk), .R(R),
        .cpu_req(cpu_req[1]), .cpu_rw(cpu_rw[1]), .cpu_size(cpu_size[1]),
        .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
        .cpu_gnt(cpu_gnt[1]), .cpu_done(cpu_done[1]), .cpu_rdata(cpu_rdata[1]),
        .cpu_stall(cpu_stall[1]),
        .ldr_req(ldr_req[1]), .ldr_rw(ldr_rw[1]), .ldr_size(ldr_size[1]),
        .ldr_addr(ldr_addr[1]), .ldr_wdata(ldr_wdata[1]),
        .ldr_gnt(ldr_gnt[1]), .ldr_done(ldr_done[1]), .ldr_rdata(ldr_rdata[1]),
        .ram_E(ram_E[1]), .ram_RW(ram_RW[1]), .ram_Size(ram_Size[1]),
        .ram_A(ram_A[1]), .ram_DI(ram_DI[1]), .ram_DO(ram_DO[1])
    );

    // Little-endian byte RAM per instance, driven by the DUT's RAM port.
    logic [7:0] emem [2][256];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            if (ram_Size[k])
                ram_DO[k] = {emem[k][ram_A[k] + 8'd3], emem[k][ram_A[k] + 8'd2],
                             emem[k][ram_A[k] + 8'd1], emem[k][ram_A[k]]};
            else
                ram_DO[k] = {24'h0, emem[k][ram_A[k]]};
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ram_E[k] && ram_RW[k]) begin
                emem[k][ram_A[k]] <= ram_DI[k][7:0];
                if (ram_Size[k]) begin
                    emem[k][ram_A[k] + 8'd1] <= ram_DI[k][15:8];
                    emem[k][ram_A[k] + 8'd2] <= ram_DI[k][23:16];
                    emem[k][ram_A[k] + 8'd3] <= ram_DI[k][31:24];
                end
            end
        end
    end

    // Transaction-level model: busy counts cycles left until the requester
    // is free again (access cycles followed by one done cycle).
    int          busy [2], owner [2], last [2];
    logic        lrw [2], lsize [2];
    logic [7:0]  laddr [2];
    logic [31:0] lwd [2];
    logic [31:0] mrd [2][2];
    logic [7:0]  mmem [2][256];

    function automatic int ac(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int pick(int k);
        if (cpu_req[k] && ldr_req[k]) begin
`ifdef ARB_ROUND_ROBIN_EN
            return (last[k] == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        if (cpu_req[k]) return 0;
        if (ldr_req[k]) return 1;
        return -1;
    endfunction

    task automatic model_reset(int k);
        busy[k]   = 0;
        owner[k]  = 0;
        last[k]   = 1;
        lrw[k]    = 1'b0;
        lsize[k]  = 1'b0;
        laddr[k]  = 8'h00;
        lwd[k]    = 32'h0;
        mrd[k][0] = 32'h0;
        mrd[k][1] = 32'h0;
    endtask

    task automatic model_step(int k);
        int w;
        if (busy[k] == 0) begin
            w = pick(k);
            if (w >= 0) begin
                owner[k] = w;
                last[k]  = w;
                busy[k]  = ac(k) + 1;
                lrw[k]   = (w == 0) ? cpu_rw[k]    : ldr_rw[k];
                lsize[k] = (w == 0) ? cpu_size[k]  : ldr_size[k];
                laddr[k] = (w == 0) ? cpu_addr[k]  : ldr_addr[k];
                lwd[k]   = (w == 0) ? cpu_wdata[k] : ldr_wdata[k];
            end
        end else begin
            if (busy[k] == 2) begin
                if (lrw[k]) begin
                    mmem[k][laddr[k]] = lwd[k][7:0];
                    if (lsize[k]) begin
                        mmem[k][laddr[k] + 8'd1] = lwd[k][15:8];
                        mmem[k][laddr[k] + 8'd2] = lwd[k][23:16];
                        mmem[k][laddr[k] + 8'd3] = lwd[k][31:24];
                    end
                end else if (lsize[k]) begin
                    mrd[k][owner[k]] = {mmem[k][laddr[k] + 8'd3], mmem[k][laddr[k] + 8'd2],
                                        mmem[k][laddr[k] + 8'd1], mmem[k][laddr[k]]};
                end else begin
                    mrd[k][owner[k]] = {24'h0, mmem[k][laddr[k]]};
                end
            end
            busy[k]--;
        end
    endtask

    task automatic compare(string nm, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s[u%0d] got %h expected %h at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic checkOutput(int k);
        int   w;
        logic e_cdone, e_ldone, e_en;
        w       = (busy[k] == 0 && !R) ? pick(k) : -1;
        e_cdone = (busy[k] == 1) && (owner[k] == 0);
        e_ldone = (busy[k] == 1) && (owner[k] == 1);
        e_en    = (busy[k] >= 2);
        compare("cpu_gnt",   k, 32'(cpu_gnt[k]),   32'(w == 0));
        compare("ldr_gnt",   k, 32'(ldr_gnt[k]),   32'(w == 1));
        compare("cpu_done",  k, 32'(cpu_done[k]),  32'(e_cdone));
        compare("ldr_done",  k, 32'(ldr_done[k]),  32'(e_ldone));
        compare("cpu_stall", k, 32'(cpu_stall[k]), 32'(cpu_req[k] && !e_cdone));
        compare("ram_E",     k, 32'(ram_E[k]),     32'(e_en));
        compare("ram_RW",    k, 32'(ram_RW[k]),    32'(e_en && lrw[k]));
        compare("ram_Size",  k, 32'(ram_Size[k]),  32'(lsize[k]));
        compare("ram_A",     k, 32'(ram_A[k]),     32'(laddr[k]));
        compare("ram_DI",    k, ram_DI[k],         lwd[k]);
        compare("cpu_rdata", k, cpu_rdata[k],      mrd[k][0]);
        compare("ldr_rdata", k, ldr_rdata[k],      mrd[k][1]);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) model_reset(k);
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (R) model_reset(k);
                checkOutput(k);
            end
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (R) model_reset(k);
                else   model_step(k);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(int k, int who, logic req, logic rw, logic sz,
                                 logic [7:0] addr, logic [31:0] wd);
        if (who == 0) begin
            cpu_req[k] = req; cpu_rw[k] = rw; cpu_size[k] = sz;
            cpu_addr[k] = addr; cpu_wdata[k] = wd;
        end else begin
            ldr_req[k] = req; ldr_rw[k] = rw; ldr_size[k] = sz;
            ldr_addr[k] = addr; ldr_wdata[k] = wd;
        end
    endtask

    task automatic wait_done(int k, int who, int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (((who == 0) ? cpu_done[k] : ldr_done[k]) === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("[TB] FAIL done_timeout[u%0d] got none expected pulse within %0d cycles", k, budget);
        end
    endtask

    initial begin
        int         e_cnt, d_cnt, n;
        logic [3:0] g;
        logic [3:0] g_exp;

        R = 1'b1;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(k, 0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
            applyStimulus(k, 1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        end
        cpu_req[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare("rst_gnt_masked", 0, 32'(cpu_gnt[0]), 32'h0);
        compare("rst_ram_E",      0, 32'(ram_E[0]),   32'h0);
        compare("rst_ram_A",      1, 32'(ram_A[1]),   32'h0);
        compare("rst_cpu_rdata",  1, cpu_rdata[1],    32'h0);
        tick;
        R = 1'b0;
        cpu_req[0] = 1'b0;
        repeat (2) tick;

        // CPU word write, one-cycle access.
        applyStimulus(0, 0, 1'b1, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
        @(negedge clk);
        compare("wr_gnt",   0, 32'(cpu_gnt[0]),   32'h1);
        compare("wr_stall", 0, 32'(cpu_stall[0]), 32'h1);
        @(negedge clk);
        compare("wr_ram_E",  0, 32'(ram_E[0]),   32'h1);
        compare("wr_ram_RW", 0, 32'(ram_RW[0]),  32'h1);
        compare("wr_ram_A",  0, 32'(ram_A[0]),   32'h10);
        compare("wr_ram_DI", 0, ram_DI[0],       32'hDEADBEEF);
        compare("wr_stall2", 0, 32'(cpu_stall[0]), 32'h1);
        @(negedge clk);
        compare("wr_done",   0, 32'(cpu_done[0]),  32'h1);
        compare("wr_e_low",  0, 32'(ram_E[0]),     32'h0);
        compare("wr_unstal", 0, 32'(cpu_stall[0]), 32'h0);
        tick;
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b1, 8'h10, 32'h0);
        repeat (2) tick;

        // Word and byte read-back.
        applyStimulus(0, 0, 1'b1, 1'b0, 1'b1, 8'h10, 32'h0);
        wait_done(0, 0, 10);
        compare("rd_word",     0, cpu_rdata[0], 32'hDEADBEEF);
        compare("rd_ldr_kept", 0, ldr_rdata[0], 32'h0);
        compare("model_rd",    0, mrd[0][0],    32'hDEADBEEF);
        tick;
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 8'h11, 32'h0);
        repeat (2) tick;
        applyStimulus(0, 0, 1'b1, 1'b0, 1'b0, 8'h11, 32'h0);
        wait_done(0, 0, 10);
        compare("rd_byte", 0, cpu_rdata[0], 32'h000000BE);
        tick;
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        repeat (3) tick;

        // Loader byte write, three-cycle access, request and fields dropped after grant.
        applyStimulus(1, 1, 1'b1, 1'b1, 1'b0, 8'h20, 32'h000000A5);
        @(negedge clk);
        compare("ld_gnt", 1, 32'(ldr_gnt[1]), 32'h1);
        tick;
        applyStimulus(1, 1, 1'b0, 1'b0, 1'b1, 8'h55, 32'hFFFFFFFF);
        e_cnt = 0;
        d_cnt = 0;
        @(negedge clk);
        compare("ld_ram_A",    1, 32'(ram_A[1]),    32'h20);
        compare("ld_ram_Size", 1, 32'(ram_Size[1]), 32'h0);
        compare("ld_ram_DI",   1, ram_DI[1],        32'h000000A5);
        if (ram_E[1])    e_cnt++;
        if (ldr_done[1]) d_cnt++;
        repeat (7) begin
            @(negedge clk);
            if (ram_E[1])    e_cnt++;
            if (ldr_done[1]) d_cnt++;
        end
        compare("ld_e_cycles", 1, 32'(e_cnt), 32'd3);
        compare("ld_done_cnt", 1, 32'(d_cnt), 32'd1);
        tick;
        applyStimulus(1, 0, 1'b1, 1'b0, 1'b0, 8'h20, 32'h0);
        wait_done(1, 0, 12);
        compare("ld_readback", 1, cpu_rdata[1], 32'h000000A5);
        compare("ld_wr_keeps", 1, ldr_rdata[1], 32'h0);
        tick;
        applyStimulus(1, 0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        repeat (3) tick;

        // Reset in the second access cycle of a three-cycle write.
        applyStimulus(1, 0, 1'b1, 1'b1, 1'b1, 8'h40, 32'h12345678);
        @(negedge clk);
        compare("ab_gnt", 1, 32'(cpu_gnt[1]), 32'h1);
        tick;
        tick;
        R = 1'b1;
        applyStimulus(1, 0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        compare("ab_ram_E",  1, 32'(ram_E[1]),    32'h0);
        compare("ab_done",   1, 32'(cpu_done[1]), 32'h0);
        compare("ab_ram_A",  1, 32'(ram_A[1]),    32'h0);
        compare("ab_ram_DI", 1, ram_DI[1],        32'h0);
        compare("ab_rdata",  1, cpu_rdata[1],     32'h0);
        tick;
        R = 1'b0;
        d_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (cpu_done[1]) d_cnt++;
        end
        compare("ab_no_done", 1, 32'(d_cnt), 32'd0);
        tick;
        applyStimulus(1, 1, 1'b1, 1'b0, 1'b0, 8'h20, 32'h0);
        wait_done(1, 1, 12);
        compare("ab_restart", 1, ldr_rdata[1], 32'h000000A5);
        tick;
        applyStimulus(1, 1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        repeat (3) tick;

        // Contention: both requesters held for four grants.
        applyStimulus(0, 0, 1'b1, 1'b0, 1'b1, 8'h10, 32'h0);
        applyStimulus(0, 1, 1'b1, 1'b0, 1'b0, 8'h11, 32'h0);
        g = 4'b0000;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (cpu_gnt[0]) begin
                n++;
            end else if (ldr_gnt[0]) begin
                g[n] = 1'b1;
                n++;
            end
        end
`ifdef ARB_ROUND_ROBIN_EN
        g_exp = 4'b1010;
`else
        g_exp = 4'b0000;
`endif
        compare("arb_grants", 0, 32'(n), 32'd4);
        compare("arb_order",  0, 32'(g), 32'(g_exp));
        tick;
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        applyStimulus(0, 1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        repeat (6) tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ACCESS_CYCLES, default 1, number of cycles RAM control lines are held per access; legal range 1-15.
REQ-002 Parameter ADDR_W, default 8, RAM byte-address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 R  input  1  reset, asynchronous, active-high.
REQ-005 cpu_req  input  1  CPU MEM-stage access request, level.
REQ-006 cpu_rw / cpu_size  input  1 / 1  CPU write(1)/read(0); word(1)/byte(0).
REQ-007 cpu_addr / cpu_wdata  input  ADDR_W / 32  CPU address and write data.
REQ-008 cpu_gnt / cpu_done  output  1 / 1  CPU grant pulse; completion pulse.
REQ-009 cpu_rdata  output  32  CPU read data, registered.
REQ-010 cpu_stall  output  1  freezes PC/IF_ID while a CPU access is pending.
REQ-011 ldr_req, ldr_rw, ldr_size, ldr_addr, ldr_wdata, ldr_gnt, ldr_done, ldr_rdata  same directions/widths as CPU set  loader (preload/debug) requester.
REQ-012 ram_E, ram_RW, ram_Size  output  1 each  RAM enable, write, size.
REQ-013 ram_A / ram_DI  output  ADDR_W / 32  RAM address / write data.
REQ-014 ram_DO  input  32  RAM read data, combinational from RAM.

Function
REQ-015 FSM states IDLE, ACCESS, DONE; two-bit owner/last-grant register; cycle counter of 4 bits.
REQ-016 IDLE: if any req asserted, select winner, latch its rw/size/addr/wdata, assert its gnt for exactly one cycle, load counter with ACCESS_CYCLES-1, go ACCESS; else stay IDLE.
REQ-017 ACCESS: ram_E=1 and ram_RW/Size/A/DI driven from latched fields; counter decrements each cycle; at counter 0, reads capture ram_DO into owner's rdata, go DONE.
REQ-018 Outside ACCESS, ram_E=0 and ram_RW=0; ram_A/DI/Size hold last latched values.
REQ-019 DONE: owner's done=1 for one cycle; go IDLE; no grant issued in DONE.
REQ-020 Latency: req seen in IDLE at edge N -> gnt in cycle N, done in cycle N+ACCESS_CYCLES+1; back-to-back accesses separated by one IDLE cycle.
REQ-021 rdata of each requester holds until that requester's next read completes; writes leave rdata unchanged.
REQ-022 Requester dropping req or changing fields during ACCESS: access completes with latched values; done still pulses.
REQ-023 cpu_stall = cpu_req AND NOT cpu_done, combinational.
REQ-024 Addresses pass through unmodified; no wrap or alignment checks (RAM owns word-at-top-of-memory behaviour).
REQ-025 Non-owner gnt/done remain 0 throughout another requester's access.

Reset
REQ-026 R=1 forces immediately: state IDLE, counter 0, all gnt/done/ram_E/ram_RW 0, ram_A/DI/Size 0, both rdata 0, last-grant = loader.
REQ-027 R asserted mid-ACCESS aborts the access; no done pulse; after release arbitration restarts from IDLE.

Configuration
REQ-028 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous requests in IDLE, grant the requester not granted last; single request always granted.
REQ-029 Macro undefined: fixed priority, CPU always wins simultaneous requests; last-grant register still present but unused for selection.

Structure
REQ-030 Shared package arb_pkg holds state encoding (IDLE/ACCESS/DONE), requester IDs (REQ_CPU=0, REQ_LDR=1), and ACCESS_CYCLES bound constant.
REQ-031 One sub-module arb_select: combinational winner choice from cpu_req, ldr_req, last-grant, with the ARB_ROUND_ROBIN_EN variant inside it.

Verification
REQ-032 CPU write word 0xDEADBEEF to 0x10, ACCESS_CYCLES=1 -> ram_E=1, ram_RW=1, ram_A=0x10 for one cycle; cpu_done 2 cycles after gnt; cpu_stall high until done.
REQ-033 CPU read word 0x10 after REQ-032 -> cpu_rdata=0xDEADBEEF at done; ldr_rdata unchanged (0).
REQ-034 Both req together, four consecutive accesses, macro defined -> grants CPU, LDR, CPU, LDR; macro undefined -> CPU x4, LDR never granted while cpu_req held.
REQ-035 ACCESS_CYCLES=3, loader byte write 0xA5 to 0x20, ldr_req dropped after gnt -> ram_E high exactly 3 cycles, ldr_done pulses once.
REQ-036 R pulsed during second ACCESS cycle (ACCESS_CYCLES=3) -> ram_E drops immediately, no done, all outputs zero; next request granted normally.
